// File: rtl/synth_cmd_pkg.sv
// Shared opcode constants, decoder state enum and payload-length lookup for synth_cmd_decoder.
package synth_cmd_pkg;

  // Longest payload (3 bytes); payloads are shifted in LSB first from the top.
  localparam int unsigned PAYLOAD_BITS = 24;

  localparam logic [7:0] OP_SET_MOD_FCW     = 8'h01;
  localparam logic [7:0] OP_SET_MOD_SHIFT   = 8'h02;
  localparam logic [7:0] OP_NOTE_START      = 8'h03;
  localparam logic [7:0] OP_NOTE_STOP       = 8'h04;
  localparam logic [7:0] OP_SET_SYNTH_SHIFT = 8'h05;

  typedef enum logic [1:0] {
    StIdle,
    StPayload,
    StExec
  } state_e;

  // Zero marks an illegal opcode.
  function automatic logic [1:0] payload_len(input logic [7:0] op);
    logic [1:0] len;
    case (op)
      OP_SET_MOD_FCW, OP_NOTE_START, OP_NOTE_STOP: len = 2'd3;
      OP_SET_MOD_SHIFT, OP_SET_SYNTH_SHIFT:        len = 2'd1;
      default:                                     len = 2'd0;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/synth_voice_alloc.sv
// Combinational voice search: lowest enabled voice holding fcw, and lowest disabled voice.
module synth_voice_alloc #(
  parameter int unsigned N_VOICES  = 4,
  parameter int unsigned FCW_WIDTH = 24,
  parameter int unsigned IDX_W     = 2
) (
  input  logic [N_VOICES-1:0]           note_en,
  input  logic [N_VOICES*FCW_WIDTH-1:0] carrier_fcws,
  input  logic [FCW_WIDTH-1:0]          fcw,
  output logic                          match_hit,
  output logic [IDX_W-1:0]              match_idx,
  output logic                          free_hit,
  output logic [IDX_W-1:0]              free_idx
);

  // Scan high to low so the last assignment wins with the lowest index.
  always_comb begin
    match_hit = 1'b0;
    match_idx = '0;
    free_hit  = 1'b0;
    free_idx  = '0;
    for (int i = N_VOICES - 1; i >= 0; i--) begin
      if (note_en[i] && (carrier_fcws[i*FCW_WIDTH +: FCW_WIDTH] == fcw)) begin
        match_hit = 1'b1;
        match_idx = IDX_W'(i);
      end
      if (!note_en[i]) begin
        free_hit = 1'b1;
        free_idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/synth_cmd_decoder.sv
// UART byte-stream command decoder feeding the synth register bank.
// Optional inter-byte payload timeout enabled by defining SYNTH_CMD_TIMEOUT_EN.
module synth_cmd_decoder
  import synth_cmd_pkg::*;
#(
  parameter int unsigned N_VOICES       = 4,
  parameter int unsigned FCW_WIDTH      = 24,
  parameter int unsigned SHIFT_WIDTH    = 5,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    rx_data,
  input  logic                          rx_valid,
  output logic                          rx_ready,
  output logic [FCW_WIDTH-1:0]          mod_fcw,
  output logic [SHIFT_WIDTH-1:0]        mod_shift,
  output logic [SHIFT_WIDTH-1:0]        synth_shift,
  output logic [N_VOICES*FCW_WIDTH-1:0] carrier_fcws,
  output logic [N_VOICES-1:0]           note_en,
  output logic                          err
);

  localparam int unsigned IdxW = (N_VOICES > 1) ? $clog2(N_VOICES) : 1;

  state_e                              state_q, state_d;
  logic [7:0]                          op_q, op_d;
  logic [1:0]                          cnt_q, cnt_d;
  logic [PAYLOAD_BITS-1:0]             sh_q, sh_d;
  logic [FCW_WIDTH-1:0]                mod_fcw_q, mod_fcw_d;
  logic [SHIFT_WIDTH-1:0]              mod_shift_q, mod_shift_d;
  logic [SHIFT_WIDTH-1:0]              synth_shift_q, synth_shift_d;
  logic [N_VOICES-1:0][FCW_WIDTH-1:0]  carrier_q, carrier_d;
  logic [N_VOICES-1:0]                 note_en_q, note_en_d;
  logic                                err_q, err_d;

  logic                   rx_fire;
  logic                   timeout;
  logic [FCW_WIDTH-1:0]   pay_fcw;
  logic [SHIFT_WIDTH-1:0] pay_shift;
  logic                   match_hit, free_hit;
  logic [IdxW-1:0]        match_idx, free_idx;

  assign rx_ready  = ~rst & (state_q != StExec);
  assign rx_fire   = rx_valid & rx_ready;
  assign pay_fcw   = sh_q[FCW_WIDTH-1:0];
  // One-byte payloads land in the top byte after a single shift.
  assign pay_shift = sh_q[PAYLOAD_BITS-8 +: SHIFT_WIDTH];

`ifdef SYNTH_CMD_TIMEOUT_EN
  localparam int unsigned ToW = $clog2(TIMEOUT_CYCLES + 1);
  logic [ToW-1:0] to_cnt_q;

  always_ff @(posedge clk) begin
    if (rst || rx_fire || (state_q != StPayload)) begin
      to_cnt_q <= '0;
    end else if (!timeout) begin
      to_cnt_q <= to_cnt_q + 1'b1;
    end
  end

  assign timeout = (state_q == StPayload) && !rx_fire && (to_cnt_q == ToW'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign timeout        = 1'b0;
`endif

  synth_voice_alloc #(
    .N_VOICES  (N_VOICES),
    .FCW_WIDTH (FCW_WIDTH),
    .IDX_W     (IdxW)
  ) u_voice_alloc (
    .note_en      (note_en_q),
    .carrier_fcws (carrier_q),
    .fcw          (pay_fcw),
    .match_hit    (match_hit),
    .match_idx    (match_idx),
    .free_hit     (free_hit),
    .free_idx     (free_idx)
  );

  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    cnt_d         = cnt_q;
    sh_d          = sh_q;
    mod_fcw_d     = mod_fcw_q;
    mod_shift_d   = mod_shift_q;
    synth_shift_d = synth_shift_q;
    carrier_d     = carrier_q;
    note_en_d     = note_en_q;
    err_d         = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (rx_fire) begin
          if (payload_len(rx_data) == 2'd0) begin
            err_d = 1'b1;
          end else begin
            op_d    = rx_data;
            cnt_d   = payload_len(rx_data);
            sh_d    = '0;
            state_d = StPayload;
          end
        end
      end
      StPayload: begin
        if (rx_fire) begin
          sh_d  = {rx_data, sh_q[PAYLOAD_BITS-1:8]};
          cnt_d = cnt_q - 2'd1;
          if (cnt_q == 2'd1) begin
            state_d = StExec;
          end
        end else if (timeout) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end
      end
      StExec: begin
        state_d = StIdle;
        unique case (op_q)
          OP_SET_MOD_FCW:     mod_fcw_d     = pay_fcw;
          OP_SET_MOD_SHIFT:   mod_shift_d   = pay_shift;
          OP_SET_SYNTH_SHIFT: synth_shift_d = pay_shift;
          OP_NOTE_START: begin
            // A note already sounding is not restarted on another voice.
            if (!match_hit) begin
              if (free_hit) begin
                carrier_d[free_idx] = pay_fcw;
                note_en_d[free_idx] = 1'b1;
              end else begin
                err_d = 1'b1;
              end
            end
          end
          OP_NOTE_STOP: begin
            if (match_hit) begin
              note_en_d[match_idx] = 1'b0;
            end else begin
              err_d = 1'b1;
            end
          end
          default: ;
        endcase
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      op_q          <= '0;
      cnt_q         <= '0;
      sh_q          <= '0;
      mod_fcw_q     <= '0;
      mod_shift_q   <= '0;
      synth_shift_q <= '0;
      carrier_q     <= '0;
      note_en_q     <= '0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      cnt_q         <= cnt_d;
      sh_q          <= sh_d;
      mod_fcw_q     <= mod_fcw_d;
      mod_shift_q   <= mod_shift_d;
      synth_shift_q <= synth_shift_d;
      carrier_q     <= carrier_d;
      note_en_q     <= note_en_d;
      err_q         <= err_d;
    end
  end

  assign mod_fcw      = mod_fcw_q;
  assign mod_shift    = mod_shift_q;
  assign synth_shift  = synth_shift_q;
  assign carrier_fcws = carrier_q;
  assign note_en      = note_en_q;
  assign err          = err_q;

endmodule
